// File: rtl/z80_bus_cycle_ctrl_if.sv
// Z80 bus-cycle sequencer signal bundle: request handshake from control logic plus the external pin set.
// Latency: none (wires only).
// Backpressure: a request transfers only when req_valid & req_ready are both high on a rising clk edge.
//
// Ports carried (slave = sequencer side):
//   req_valid/req_type/req_addr/req_wdata -> request in; req_ready, done, rdata <- status out
//   data_in, WAIT_L, BUSREQ_L             -> bus inputs
//   data_out/data_oe, addr_out/addr_oe, M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L <- pins out
interface z80_bus_cycle_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_type;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        done;
  logic [7:0]  rdata;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [15:0] addr_out;
  logic        addr_oe;
  logic        M1_L;
  logic        MREQ_L;
  logic        IORQ_L;
  logic        RD_L;
  logic        WR_L;
  logic        RFSH_L;
  logic        WAIT_L;
  logic        BUSREQ_L;
  logic        BUSACK_L;

  modport slave (
    input  req_valid, req_type, req_addr, req_wdata, data_in, WAIT_L, BUSREQ_L,
    output req_ready, done, rdata, data_out, data_oe, addr_out, addr_oe,
           M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L
  );

  modport master (
    output req_valid, req_type, req_addr, req_wdata, data_in, WAIT_L, BUSREQ_L,
    input  req_ready, done, rdata, data_out, data_oe, addr_out, addr_oe,
           M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L
  );
endinterface

// File: rtl/z80_bus_cycle_ctrl.sv
// Z80 machine-cycle sequencer: runs OCF / MRD / MWR / IORD / IOWR cycles T-state by T-state, plus refresh and bus handover.
// Latency: request accepted in IDLE or final T-state, T1 on the next clock; 4 (OCF) or 3 (mem) or 3+IO_AUTO_WAIT (I/O) cycles plus WAIT_L stretch.
// Backpressure: req_ready low mid-cycle, in BUSGNT, while BUSREQ_L is low, for illegal req_type, and during rst.
//
// Ports: clk, rst (async active-high), bus (z80_bus_cycle_ctrl_if.slave: request handshake, done/rdata, Z80 pins).
module z80_bus_cycle_ctrl #(
  parameter int RFSH_BITS    = 7,
  parameter int IO_AUTO_WAIT = 1
) (
  input logic                  clk,
  input logic                  rst,
  z80_bus_cycle_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_T1     = 3'd1;
  localparam logic [2:0] S_T2     = 3'd2;
  localparam logic [2:0] S_TW     = 3'd3;
  localparam logic [2:0] S_T3     = 3'd4;
  localparam logic [2:0] S_T4     = 3'd5;
  localparam logic [2:0] S_BUSGNT = 3'd6;

  localparam logic [2:0] TY_OCF  = 3'd0;
  localparam logic [2:0] TY_MRD  = 3'd1;
  localparam logic [2:0] TY_MWR  = 3'd2;
  localparam logic [2:0] TY_IORD = 3'd3;
  localparam logic [2:0] TY_IOWR = 3'd4;

  localparam int         WCW    = $clog2(IO_AUTO_WAIT + 2);
  // Bits of R that count; anything above is left untouched by refresh.
  localparam logic [7:0] R_MASK = 8'((1 << RFSH_BITS) - 1);

  logic [2:0]     state;
  logic [2:0]     typ;
  logic [15:0]    addr_q;
  logic [7:0]     wdata_q;
  logic [7:0]     rdata_q;
  logic [7:0]     r_q;
  logic [WCW-1:0] wcnt;

  logic is_ocf, is_io, req_legal, final_t, slot_open, accept;
  logic mand_start, wait_sample;
  logic cyc_123, strb_phase, fetch_phase, rfsh_phase;

  assign is_ocf    = (typ == TY_OCF);
  assign is_io     = (typ == TY_IORD) || (typ == TY_IOWR);
  assign req_legal = (bus.req_type <= TY_IOWR);

  // OCF ends in T4 (refresh tail); every other cycle type ends in T3.
  assign final_t   = (state == S_T4) || ((state == S_T3) && !is_ocf);
  assign slot_open = (state == S_IDLE) || final_t;
  assign accept    = bus.req_valid && bus.req_ready;

  // I/O cycles enter their mandatory wait straight from T2 without looking at WAIT_L;
  // WAIT_L is only honoured once the mandatory count has run out.
  assign mand_start  = (state == S_T2) && is_io && (IO_AUTO_WAIT > 0);
  assign wait_sample = ((state == S_T2) && !mand_start) || ((state == S_TW) && (wcnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      typ     <= TY_OCF;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      r_q     <= '0;
      wcnt    <= '0;
    end else begin
      if (slot_open) begin
        // Bus handover wins over a pending request.
        if (!bus.BUSREQ_L) begin
          state <= S_BUSGNT;
        end else if (accept) begin
          state   <= S_T1;
          typ     <= bus.req_type;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
        end else begin
          state <= S_IDLE;
        end
      end else begin
        case (state)
          S_T1: state <= S_T2;
          S_T2, S_TW: begin
            if (mand_start) begin
              state <= S_TW;
              wcnt  <= WCW'(IO_AUTO_WAIT - 1);
            end else if (!wait_sample) begin
              wcnt <= wcnt - 1'b1;
            end else if (bus.WAIT_L) begin
              state <= S_T3;
            end else begin
              state <= S_TW;
            end
          end
          S_T3:     state <= S_T4;  // only an OCF is non-final in T3
          S_BUSGNT: if (bus.BUSREQ_L) state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end

      // Opcode is latched on the way out of T2/TW; memory and I/O reads at the end of T3.
      if (is_ocf && wait_sample && bus.WAIT_L) begin
        rdata_q <= bus.data_in;
      end else if ((state == S_T3) && ((typ == TY_MRD) || (typ == TY_IORD))) begin
        rdata_q <= bus.data_in;
      end

      if (state == S_T4) begin
        r_q <= (r_q & ~R_MASK) | ((r_q + 8'd1) & R_MASK);
      end
    end
  end

  assign cyc_123     = (state == S_T1) || (state == S_T2) || (state == S_TW) || (state == S_T3);
  assign strb_phase  = (state == S_T2) || (state == S_TW) || (state == S_T3);
  assign fetch_phase = is_ocf && ((state == S_T1) || (state == S_T2) || (state == S_TW));
  assign rfsh_phase  = is_ocf && ((state == S_T3) || (state == S_T4));

  assign bus.req_ready = !rst && slot_open && bus.BUSREQ_L && req_legal;
  assign bus.done      = final_t;
  assign bus.rdata     = rdata_q;

  assign bus.M1_L   = !fetch_phase;
  assign bus.MREQ_L = !(fetch_phase || rfsh_phase ||
                        (((typ == TY_MRD) || (typ == TY_MWR)) && cyc_123));
  assign bus.RD_L   = !(fetch_phase || ((typ == TY_MRD) && cyc_123) ||
                        ((typ == TY_IORD) && strb_phase));
  assign bus.WR_L   = !(((typ == TY_MWR) || (typ == TY_IOWR)) && strb_phase);
  assign bus.IORQ_L = !(is_io && strb_phase);
  assign bus.RFSH_L = !rfsh_phase;

  assign bus.data_oe  = ((typ == TY_MWR) || (typ == TY_IOWR)) && cyc_123;
  assign bus.data_out = wdata_q;
  assign bus.addr_out = rfsh_phase ? {8'h00, r_q} : addr_q;
  assign bus.addr_oe  = (state != S_BUSGNT);
  assign bus.BUSACK_L = (state != S_BUSGNT);

endmodule

// File: tb/tb_z80_bus_cycle_ctrl.sv
// Self-checking bench for z80_bus_cycle_ctrl: directed scenarios plus randomized cycles against a T-state-index model.
// Latency: n/a. Backpressure: bench only issues requests when it expects req_ready.
module tb_z80_bus_cycle_ctrl;
  localparam int IOW = 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference model state
  logic [7:0]  exp_rdata;
  logic [7:0]  exp_r;
  logic [15:0] exp_addr;

  z80_bus_cycle_ctrl_if bus();

  z80_bus_cycle_ctrl #(.RFSH_BITS(7), .IO_AUTO_WAIT(IOW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [5:0] strobes;
  assign strobes = {bus.M1_L, bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L, bus.RFSH_L};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle cycles: nothing driven except the held address.
  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_strobes", 32'(strobes), 32'h3f);
      chk("idle_addr", 32'(bus.addr_out), 32'(exp_addr));
      chk("idle_addr_oe", 32'(bus.addr_oe), 32'd1);
      chk("idle_data_oe", 32'(bus.data_oe), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_busack", 32'(bus.BUSACK_L), 32'd1);
      chk("idle_rdata", 32'(bus.rdata), 32'(exp_rdata));
      chk("idle_ready", 32'(bus.req_ready), 32'(bus.BUSREQ_L && (bus.req_type <= 3'd4)));
    end
  endtask

  // Issue one request (DUT must be idle or in a final T-state) and check every cycle of it.
  // nw = extra WAIT_L-induced TW states; noise pulls WAIT_L low while it must be ignored (I/O mandatory wait);
  // breq_at = cycle index at which BUSREQ_L is pulled low (-1 for never).
  task automatic do_cycle(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] din, input int nw, input bit noise, input int breq_at);
    int L, k3, s, cap, iow;
    bit ocf, io;
    logic [5:0] es;
    ocf = (t == 3'd0);
    io  = (t == 3'd3) || (t == 3'd4);
    iow = io ? IOW : 0;
    L   = 3 + nw + iow + (ocf ? 1 : 0);
    k3  = ocf ? 2 + nw : L - 1;           // index of T3
    s   = 1 + iow;                        // first cycle whose WAIT_L is honoured
    cap = ocf ? 1 + nw : (((t == 3'd1) || (t == 3'd3)) ? L - 1 : -1);

    bus.req_valid = 1'b1;
    bus.req_type  = t;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    #1;
    chk("accept_ready", 32'(bus.req_ready), 32'(bus.BUSREQ_L));

    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      es[5] = !(ocf && k < k3);
      es[4] = !(t <= 3'd2);
      es[3] = !(io && k >= 1);
      es[2] = !((ocf && k < k3) || t == 3'd1 || (t == 3'd3 && k >= 1));
      es[1] = !((t == 3'd2 || t == 3'd4) && k >= 1);
      es[0] = !(ocf && k >= k3);
      chk("cyc_strobes", 32'(strobes), 32'(es));
      chk("cyc_addr", 32'(bus.addr_out), (ocf && k >= k3) ? 32'({8'h00, exp_r}) : 32'(a));
      chk("cyc_addr_oe", 32'(bus.addr_oe), 32'd1);
      chk("cyc_busack", 32'(bus.BUSACK_L), 32'd1);
      chk("cyc_data_oe", 32'(bus.data_oe), 32'(t == 3'd2 || t == 3'd4));
      if (t == 3'd2 || t == 3'd4) chk("cyc_data_out", 32'(bus.data_out), 32'(wd));
      chk("cyc_done", 32'(bus.done), 32'(k == L - 1));
      chk("cyc_ready", 32'(bus.req_ready), 32'((k == L - 1) && bus.BUSREQ_L));
      chk("cyc_rdata", 32'(bus.rdata), 32'(exp_rdata));
      // Inputs seen at the end of this cycle
      bus.WAIT_L  = !((k >= s && k < s + nw) || (noise && io && k >= 1 && k < s));
      bus.data_in = (k == cap) ? din : ~din;
      if (k == cap) exp_rdata = din;
      if (k == breq_at) bus.BUSREQ_L = 1'b0;
      if (ocf && k == L - 1) exp_r = {exp_r[7], exp_r[6:0] + 7'd1};
    end
    exp_addr = a;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_rdata = 8'h00;
    exp_r     = 8'h00;
    exp_addr  = 16'h0000;
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_type  = 3'd0;
    bus.req_addr  = 16'h1111;
    bus.req_wdata = 8'h00;
    bus.data_in   = 8'h00;
    bus.WAIT_L    = 1'b1;
    bus.BUSREQ_L  = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_strobes", 32'(strobes), 32'h3f);
    chk("rst_busack", 32'(bus.BUSACK_L), 32'd1);
    chk("rst_addr", 32'(bus.addr_out), 32'd0);
    chk("rst_addr_oe", 32'(bus.addr_oe), 32'd1);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_data_oe", 32'(bus.data_oe), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;

    // OCF 0100, opcode 3C, no wait; refresh address 0000, R becomes 01
    do_cycle(3'd0, 16'h0100, 8'h00, 8'h3C, 0, 1'b0, -1);
    idle_chk(1);
    chk("ocf_rdata_3c", 32'(bus.rdata), 32'h3C);

    // MRD 8000 with two wait states
    do_cycle(3'd1, 16'h8000, 8'h00, 8'(($urandom)), 2, 1'b0, -1);
    idle_chk(1);

    // Back-to-back OCF then MWR 4000/A5 (refresh address now 0001)
    do_cycle(3'd0, 16'h1234, 8'h00, 8'(($urandom)), 0, 1'b0, -1);
    do_cycle(3'd2, 16'h4000, 8'hA5, 8'h00, 0, 1'b0, -1);
    idle_chk(1);

    // IOWR port 00FE, data 07, WAIT_L high
    do_cycle(3'd4, 16'h00FE, 8'h07, 8'h00, 0, 1'b0, -1);
    idle_chk(1);

    // IORD with WAIT_L low during the mandatory wait (ignored) and one extra wait
    do_cycle(3'd3, 16'h0042, 8'h00, 8'(($urandom)), 1, 1'b1, -1);
    idle_chk(1);

    // Illegal request type is never accepted
    bus.req_valid = 1'b1;
    bus.req_type  = 3'd5;
    idle_chk(2);
    bus.req_valid = 1'b0;

    // Bus request raised at T2 of an MRD: cycle finishes, then grant; pending request held off
    do_cycle(3'd1, 16'h2000, 8'h00, 8'(($urandom)), 0, 1'b0, 1);
    bus.req_valid = 1'b1;
    bus.req_type  = 3'd1;
    bus.req_addr  = 16'h3000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gnt_busack", 32'(bus.BUSACK_L), 32'd0);
      chk("gnt_addr_oe", 32'(bus.addr_oe), 32'd0);
      chk("gnt_data_oe", 32'(bus.data_oe), 32'd0);
      chk("gnt_strobes", 32'(strobes), 32'h3f);
      chk("gnt_ready", 32'(bus.req_ready), 32'd0);
      chk("gnt_done", 32'(bus.done), 32'd0);
    end
    bus.BUSREQ_L = 1'b1;
    @(negedge clk);
    chk("rel_busack", 32'(bus.BUSACK_L), 32'd1);
    chk("rel_strobes", 32'(strobes), 32'h3f);
    chk("rel_addr_oe", 32'(bus.addr_oe), 32'd1);
    do_cycle(3'd1, 16'h3000, 8'h00, 8'(($urandom)), 0, 1'b0, -1);
    idle_chk(1);

    // 128 back-to-back OCFs: refresh counter runs through 7F -> 00
    for (int i = 0; i < 128; i++) begin
      do_cycle(3'd0, 16'($urandom), 8'h00, 8'($urandom), int'($urandom_range(0, 2)), 1'b0, -1);
    end
    idle_chk(1);

    // Randomized mix of all cycle types, waits and idle gaps
    for (int i = 0; i < 40; i++) begin
      do_cycle(3'($urandom_range(0, 4)), 16'($urandom), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) idle_chk(1);
    end
    idle_chk(1);

    // Reset during T2 of an OCF: outputs drop back without a clock edge
    bus.req_valid = 1'b1;
    bus.req_type  = 3'd0;
    bus.req_addr  = 16'hBEEF;
    bus.WAIT_L    = 1'b1;
    #1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_strobes", 32'(strobes), 32'b001011);
    rst = 1'b1;
    #1;
    chk("async_rst_strobes", 32'(strobes), 32'h3f);
    chk("async_rst_addr", 32'(bus.addr_out), 32'd0);
    chk("async_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("async_rst_done", 32'(bus.done), 32'd0);
    chk("async_rst_rdata", 32'(bus.rdata), 32'd0);
    exp_r     = 8'h00;
    exp_rdata = 8'h00;
    exp_addr  = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    idle_chk(1);
    do_cycle(3'd0, 16'h0200, 8'h00, 8'h76, 0, 1'b0, -1);
    idle_chk(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
